fsm_rx: RTL and testbench
=========================

Name: fsm_rx

Overview:
- Serial receiver that is the far end of the 3-bit frame transmitter FSM (`tx` start, `busy`, `data[2:0]`).
- Recovers frames from a single asynchronous line: idle-high, one start bit (0), DATA_W data bits LSB first, optional parity, one stop bit (1).
- Delivers each received word with a one-cycle `valid` strobe.
- Sits between the top-level `rx` pin and consumer logic in the same clock domain.

Parameters:
- DATA_W, 3: data bits per frame.
- CLKS_PER_BIT, 16: clk cycles per bit period; must be at least 4 and even.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk, idles high.
- data  output  DATA_W  last good received word.
- valid  output  1  one-cycle pulse when `data` updates.
- busy  output  1  high while a frame is being received.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- parity_err  output  1  one-cycle pulse on parity mismatch; tied to 0 when parity is compiled out.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Input synchroniser: `rx` passes through 2 flops to give `rx_s`. Both flops reset to 1.
- Reset values: state = IDLE; `data` = 0; `valid`, `busy`, `frame_err`, `parity_err` = 0; bit counter and cycle counter = 0.
- Reset mid-frame: abandons the frame with no strobe. The receiver needs `rx_s` high before it re-arms (enters via BREAK if `rx_s` is 0).
- Cycle counter `cnt`: width clog2(CLKS_PER_BIT). Cleared on every state change.
- States and transitions:
  - IDLE: `busy` = 0. If `rx_s` == 0, go to START.
  - START: at `cnt` == CLKS_PER_BIT/2-1, sample `rx_s`.
    - Sample 0: go to DATA.
    - Sample 1: glitch; return to IDLE with no strobe.
  - DATA: at `cnt` == CLKS_PER_BIT-1, shift `rx_s` into the shift register MSB-side so bits land LSB first, then increment `bitn`.
    - After DATA_W bits, go to PARITY (feature on) or STOP.
  - PARITY: at `cnt` == CLKS_PER_BIT-1, record the mismatch (see feature), then go to STOP.
  - STOP: at `cnt` == CLKS_PER_BIT-1, sample `rx_s`.
    - Sample 1: load `data` from the shift register and pulse `valid`, unless a parity error is pending. In that case pulse `parity_err`, leave `data` unchanged, and pulse no `valid`. Go to IDLE.
    - Sample 0: pulse `frame_err`, leave `data` unchanged, and go to BREAK.
  - BREAK: `busy` = 0. Wait for `rx_s` == 1, then go to IDLE. A line held low never produces repeated frames.
- `busy`: 1 in START, DATA, PARITY and STOP.
- Strobes: `valid`, `frame_err` and `parity_err` are mutually exclusive and registered. Each is high exactly one cycle, in the cycle after the stop-bit sample.
- Latency: `valid` rises (1.5+DATA_W+P)·CLKS_PER_BIT + 3 cycles after the start-bit falling edge appears on `rx`, where P = 1 if parity is enabled, else 0. The 3 cycles are 2 for the synchroniser and 1 for the registered strobe.
- Back-to-back frames: a start edge seen in the first IDLE cycle after STOP is accepted. No dead cycles beyond one IDLE cycle.
- `data` holds its value between frames.

Optional Feature:
- Macro: FSM_RX_PARITY_EN.
- Defined:
  - Frame includes an even-parity bit after the data bits.
  - Mismatch = (XOR of data bits) XOR (parity bit) ≠ 0.
  - Mismatch is latched in PARITY and reported at STOP as above.
  - `parity_err` is live.
- Undefined:
  - No PARITY state.
  - `parity_err` is constant 0.
  - Frame length is DATA_W+2 bits.

Decomposition:
- Package `fsm_pkg`:
  - State encoding constants: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4, BREAK = 5; width 3.
  - Default DATA_W.
  - `bit_cnt_t` width helper.
- Shared with the transmitter FSM so both ends agree on encoding.
- Sub-module: `fsm_rx_sync` (2-flop synchroniser, reset value 1), reusable by other async inputs.

Test Plan (CLKS_PER_BIT = 4, DATA_W = 3):
- Reset held 3 cycles with `rx` = 1 → all outputs 0, `busy` = 0. Release → still idle.
- Frame 0,1,0,1,1 (start, data 101b LSB first, stop) → `valid` one cycle, `data` = 3'b101, `busy` high for the frame.
- `rx` low for 1 cycle only → START samples 1, back to IDLE, no strobe, `data` unchanged.
- Frame with stop bit 0, `rx` held low 20 cycles → one `frame_err` pulse, no `valid`, `busy` 0 until `rx` returns high. The next good frame 3'b011 gives `valid` with `data` = 3'b011.
- Two back-to-back frames 3'b110 then 3'b001 with no idle gap → two `valid` pulses 20 cycles apart, `data` = 3'b110 then 3'b001.
- FSM_RX_PARITY_EN defined: data 3'b111 sent with parity 0 → `parity_err` pulse and no `valid`. Same data with parity 1 → `valid` and `data` = 3'b111.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared definitions for the 3-bit frame link (transmitter and receiver FSMs).
// State encoding is fixed so both ends and any debug tooling agree on it.
package fsm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  localparam int DATA_W_DEF = 3;

  // Bits needed to count 0..n inclusive.
  function automatic int bit_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  typedef logic [$clog2(DATA_W_DEF + 1)-1:0] bit_cnt_t;

endpackage

// File: rtl/fsm_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Both stages reset high so a quiet line never looks like a start edge.
module fsm_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // capture chain: meta_r may go metastable, q_r is the settled copy
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b1;
      q_r    <= 1'b1;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/fsm_rx.sv
// Serial frame receiver: start bit, DATA_W bits LSB first, optional even
// parity (macro FSM_RX_PARITY_EN), one stop bit. Strobes are registered.
module fsm_rx
  import fsm_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = bit_cnt_w(DATA_W);
  localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_B = BW'(DATA_W - 1);

  state_t            state_r;
  state_t            state_n;
  logic [CW-1:0]     cnt_r;
  logic [BW-1:0]     bitn_r;
  logic [DATA_W-1:0] shreg_r;
  logic [DATA_W-1:0] data_r;
  logic [1:0]        settle_r;
  logic              armed_r;
  logic              rx_s;
  logic              half_s;
  logic              full_s;
  logic              par_pend_s;
  logic              valid_n;
  logic              ferr_n;
  logic              perr_n;
  logic              busy_n;
  logic              valid_r;
  logic              ferr_r;
  logic              perr_r;
  logic              busy_r;

  fsm_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign half_s = (cnt_r == HALF_C);
  assign full_s = (cnt_r == FULL_C);

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // next-state logic; an unarmed receiver treats a low line as a break, not a start
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          if (armed_r) state_n = START;
          else         state_n = BREAK;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (half_s) begin
          if (rx_s) state_n = IDLE;
          else      state_n = DATA;
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (full_s && (bitn_r == LAST_B)) begin
`ifdef FSM_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end else begin
          state_n = DATA;
        end
      end
      PARITY: begin
        if (full_s) state_n = STOP;
        else        state_n = PARITY;
      end
      STOP: begin
        if (full_s) begin
          if (rx_s) state_n = IDLE;
          else      state_n = BREAK;
        end else begin
          state_n = STOP;
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
        else      state_n = BREAK;
      end
      default: state_n = IDLE;
    endcase
  end

  // output decode: strobes fire on the stop-bit sample, busy follows the next state
  always_comb begin
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
    if ((state_r == STOP) && full_s) begin
      if (rx_s) begin
        if (par_pend_s) perr_n  = 1'b1;
        else            valid_n = 1'b1;
      end else begin
        ferr_n = 1'b1;
      end
    end else begin
      valid_n = 1'b0;
    end
    case (state_n)
      START, DATA, PARITY, STOP: busy_n = 1'b1;
      default:                   busy_n = 1'b0;
    endcase
  end

  // bit-period timing, bit counter and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= {CW{1'b0}};
      bitn_r  <= {BW{1'b0}};
      shreg_r <= {DATA_W{1'b0}};
    end else begin
      if ((state_n != state_r) || full_s || (state_r == IDLE) || (state_r == BREAK)) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (state_r == START) begin
        bitn_r  <= {BW{1'b0}};
        shreg_r <= shreg_r;
      end else if ((state_r == DATA) && full_s) begin
        bitn_r  <= bitn_r + BW'(1);
        shreg_r <= {rx_s, shreg_r[DATA_W-1:1]};
      end else begin
        bitn_r  <= bitn_r;
        shreg_r <= shreg_r;
      end
    end
  end

  // arming: the line must read high once the synchroniser holds real samples
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_r <= 2'd0;
      armed_r  <= 1'b0;
    end else begin
      settle_r <= (settle_r == 2'd2) ? 2'd2 : settle_r + 2'd1;
      if ((settle_r == 2'd2) && rx_s) armed_r <= 1'b1;
      else                            armed_r <= armed_r;
    end
  end

`ifdef FSM_RX_PARITY_EN
  logic par_err_r;

  function automatic logic par_mismatch(input logic [DATA_W-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  // even-parity check, latched until the stop bit reports it
  always_ff @(posedge clk) begin
    if (reset) begin
      par_err_r <= 1'b0;
    end else if (state_r == START) begin
      par_err_r <= 1'b0;
    end else if ((state_r == PARITY) && full_s) begin
      par_err_r <= par_mismatch(shreg_r, rx_s);
    end else begin
      par_err_r <= par_err_r;
    end
  end

  assign par_pend_s = par_err_r;
`else
  assign par_pend_s = 1'b0;
`endif

  // registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      perr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      data_r  <= valid_n ? shreg_r : data_r;
      valid_r <= valid_n;
      ferr_r  <= ferr_n;
      perr_r  <= perr_n;
      busy_r  <= busy_n;
    end
  end

  assign data       = data_r;
  assign valid      = valid_r;
  assign busy       = busy_r;
  assign frame_err  = ferr_r;
  assign parity_err = perr_r;

endmodule

// File: tb/tb_fsm_rx.sv
// Scoreboard bench for fsm_rx: the driver serialises frames and queues the
// expected strobe (kind, data, cycle); a monitor pops and checks each strobe.
`timescale 1ns/1ps
module tb_fsm_rx;

  localparam int W   = 3;
  localparam int CPB = 4;
`ifdef FSM_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT     = (3 * CPB) / 2 + (W + P) * CPB + 3;
  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx = 1'b1;
  logic [W-1:0] data;
  logic         valid, busy, frame_err, parity_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_d = 0;

  typedef struct {
    int kind;
    int d;
    int at;
  } exp_t;
  exp_t sb[$];

  fsm_rx #(.DATA_W(W), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serialise one frame and queue the strobe the receiver should produce.
  task automatic send_frame(input int d, input bit stop_b, input bit par_bad);
    exp_t e;
    logic [W-1:0] dv;
    dv   = d[W-1:0];
    e.at = cyc + LAT;
    if (!stop_b) begin
      e.kind = K_FERR;  e.d = last_d;
    end else if (par_bad) begin
      e.kind = K_PERR;  e.d = last_d;
    end else begin
      e.kind = K_VALID; e.d = int'(dv); last_d = int'(dv);
    end
    sb.push_back(e);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < W; i++) begin
      if (i == 1) check("busy_mid_frame", busy, 1);
      rx = dv[i];
      repeat (CPB) tick();
    end
`ifdef FSM_RX_PARITY_EN
    rx = (^dv) ^ par_bad;
    repeat (CPB) tick();
`endif
    rx = stop_b;
    repeat (CPB) tick();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 4 * LAT) begin
      tick();
      k++;
    end
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  // monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   kind;
    if (!reset && (valid || frame_err || parity_err)) begin
      check("strobes_exclusive", $countones({valid, frame_err, parity_err}), 1);
      kind = valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, expected no strobe", kind, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", kind, e.kind);
        check("strobe_cycle", cyc, e.at);
        check("strobe_data", data, e.d);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int m, d, g;
    bit st, pb;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) tick();
    check("reset_data", data, 0);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_parity_err", parity_err, 0);
    reset = 1'b0;
    repeat (4) tick();
    check("idle_busy", busy, 0);
    check("idle_data", data, 0);

    send_frame(5, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (3) tick();

    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (10) tick();
    check("glitch_busy", busy, 0);
    check("glitch_data_held", data, last_d);

    send_frame(2, 1'b0, 1'b0);
    repeat (16) tick();
    check("break_busy", busy, 0);
    rx = 1'b1;
    repeat (4) tick();
    send_frame(3, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (3) tick();

    send_frame(6, 1'b1, 1'b0);
    send_frame(1, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (3) tick();

`ifdef FSM_RX_PARITY_EN
    send_frame(7, 1'b1, 1'b1);
    send_frame(7, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (3) tick();
`endif

    for (int n = 0; n < 40; n++) begin
      m  = $urandom_range(0, 9);
      d  = $urandom_range(0, 7);
      st = (m < 2) ? 1'b0 : 1'b1;
      pb = 1'b0;
`ifdef FSM_RX_PARITY_EN
      pb = (m == 2 || m == 3);
`endif
      send_frame(d, st, pb);
      rx = 1'b1;
      g  = st ? $urandom_range(0, 3) : $urandom_range(1, 4);
      repeat (g) tick();
    end

    drain();
    rx = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset  = 1'b0;
    last_d = 0;
    repeat (15) tick();
    check("post_reset_low_busy", busy, 0);
    check("post_reset_data", data, 0);
    rx = 1'b1;
    repeat (4) tick();
    send_frame(4, 1'b1, 1'b0);
    rx = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
